// File: rtl/dut_cmd_sequencer_pkg.sv
// Shared types for the command sequencer: command word, FSM states, target encodings.
// The command length field width is fixed here; the top's LEN_W parameter must match it.
package dut_cmd_sequencer_pkg;
    localparam int CMD_LEN_W = 4;

    localparam logic TGT_SUB1 = 1'b1;
    localparam logic TGT_SUB2 = 1'b0;

    typedef struct packed {
        logic                 target;
        logic                 write;
        logic [CMD_LEN_W-1:0] len;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} seq_state_e;
endpackage

// File: rtl/dut_cmd_sequencer_cmd_fifo.sv
// Registered command FIFO, no bypass: a pushed entry shows on rdata_o the edge after the push.
module dut_cmd_sequencer_cmd_fifo
    import dut_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/dut_cmd_sequencer.sv
// Turns queued write/read commands into CS/WE strobe sequences for the two-model DUT.
// CS only moves on the edge into SETUP, where WE is driven low.
module dut_cmd_sequencer
    import dut_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = CMD_LEN_W,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_target,
    input  logic             req_write,
    input  logic [LEN_W-1:0] req_len,
    output logic             CS,
    output logic             WE,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cmd_count
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_e           state_q;
    logic                 wr_q;
    logic [CMD_LEN_W-1:0] ln_q;
    logic [CMD_LEN_W-1:0] len_q;
    logic [GW-1:0]        gap_q;
    logic                 cs_q, we_q, done_q;
    logic [CNT_W-1:0]     cnt_q;

    cmd_t push_cmd, fifo_rdata;
    logic full, empty, push, pop, strobe_last, recover_last;

    assign push_cmd     = '{target: req_target, write: req_write, len: CMD_LEN_W'(req_len)};
    assign req_ready    = RST_N && !full;
    assign push         = req_valid && req_ready;
    assign strobe_last  = (state_q == STROBE) && (len_q == '0);
    assign recover_last = (state_q == RECOVER) && (gap_q == '0);
    // Pop on the same edge that enters SETUP, so back-to-back commands lose no cycle.
    assign pop = !empty && ((state_q == IDLE) || (strobe_last && GAP == 0) || recover_last);

    dut_cmd_sequencer_cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_cmd),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            ln_q    <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            cs_q    <= TGT_SUB2;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                wr_q    <= fifo_rdata.write;
                ln_q    <= fifo_rdata.len;
                cs_q    <= fifo_rdata.target;
                we_q    <= 1'b0;
                state_q <= SETUP;
            end else begin
                case (state_q)
                    SETUP: begin
                        len_q   <= (ln_q == '0) ? '0 : ln_q - 1'b1;
                        we_q    <= wr_q;
                        state_q <= STROBE;
                    end
                    STROBE: begin
                        if (len_q != '0) begin
                            len_q <= len_q - 1'b1;
                        end else begin
                            we_q    <= 1'b0;
                            state_q <= (GAP > 0) ? RECOVER : IDLE;
                            gap_q   <= GW'((GAP > 0) ? GAP - 1 : 0);
                        end
                    end
                    RECOVER: begin
                        if (gap_q != '0) gap_q <= gap_q - 1'b1;
                        else             state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
            if (strobe_last) begin
                done_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign CS        = cs_q;
    assign WE        = we_q;
    assign done      = done_q;
    assign cmd_count = cnt_q;
    assign busy      = (state_q != IDLE) || !empty;
endmodule
